// File: rtl/i2c_target_regfile_pkg.sv
// rtl/i2c_target_regfile_pkg.sv - shared state encoding, bus levels and address helper
package i2c_target_regfile_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ACK,
        ST_PTR,
        ST_WR_DATA,
        ST_RD_DATA,
        ST_MACK,
        ST_WAIT_STOP
    } state_t;

    localparam logic ACK_LEVEL  = 1'b0;
    localparam logic NACK_LEVEL = 1'b1;

    // Address byte on the wire is {addr[6:0], R/nW}
    function automatic logic addr_match(input logic [7:0] addr_byte, input logic [6:0] own_addr);
        return addr_byte[7:1] == own_addr;
    endfunction

endpackage

// File: rtl/i2c_target_regfile_bus_sync.sv
// rtl/i2c_target_regfile_bus_sync.sv - SCL/SDA synchroniser and bus event detector
module i2c_target_regfile_bus_sync (
    input  logic sys_clk,
    input  logic resetn,
    input  logic i_scl,
    input  logic i_sda,
    output logic o_sda,
    output logic o_scl_rise,
    output logic o_scl_fall,
    output logic o_start_det,
    output logic o_stop_det
);

    logic [1:0] r_scl_sync;
    logic [1:0] r_sda_sync;
    logic       r_scl_prev;
    logic       r_sda_prev;
    logic       w_scl;
    logic       w_sda;

    // Two-flop synchronisers plus one edge register; idle bus level is high so reset to 1
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_scl_sync <= 2'b11;
            r_sda_sync <= 2'b11;
            r_scl_prev <= 1'b1;
            r_sda_prev <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[0], i_scl};
            r_sda_sync <= {r_sda_sync[0], i_sda};
            r_scl_prev <= r_scl_sync[1];
            r_sda_prev <= r_sda_sync[1];
        end
    end

    assign w_scl       = r_scl_sync[1];
    assign w_sda       = r_sda_sync[1];
    assign o_sda       = w_sda;
    assign o_scl_rise  = w_scl & ~r_scl_prev;
    assign o_scl_fall  = ~w_scl & r_scl_prev;
    // SDA may only move while SCL is high for START/STOP, so require SCL high on both samples
    assign o_start_det = w_scl & r_scl_prev & r_sda_prev & ~w_sda;
    assign o_stop_det  = w_scl & r_scl_prev & ~r_sda_prev & w_sda;

endmodule

// File: rtl/i2c_target_regfile.sv
// rtl/i2c_target_regfile.sv - I2C target exposing a fabric-preloaded byte register file
module i2c_target_regfile
    import i2c_target_regfile_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR = 7'h28,
    parameter int         REG_ADDR_W = 6
) (
    input  logic                  sys_clk,
    input  logic                  resetn,
    input  logic                  scl_in,
    input  logic                  sda_in,
    output logic                  sda_oe,
    input  logic                  fab_wr_en,
    input  logic [REG_ADDR_W-1:0] fab_wr_addr,
    input  logic [7:0]            fab_wr_data,
    output logic                  i2c_wr_strobe,
    output logic [REG_ADDR_W-1:0] i2c_wr_addr,
    output logic [7:0]            i2c_wr_data,
    output logic                  busy
);

    localparam int DEPTH = 1 << REG_ADDR_W;

    logic                  w_sda;
    logic                  w_scl_rise;
    logic                  w_scl_fall;
    logic                  w_start_det;
    logic                  w_stop_det;
    logic [7:0]            w_rx_byte;
    logic [7:0]            w_rd_byte;

    state_t                r_state;
    state_t                r_ack_next;
    logic [3:0]            r_bit_cnt;
    logic [6:0]            r_shift;
    logic [REG_ADDR_W-1:0] r_ptr;
    logic                  r_sda_oe;
    logic                  r_busy;
    logic                  r_wr_strobe;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [7:0]            r_wr_data;
    logic [7:0]            r_mem [DEPTH];

    i2c_target_regfile_bus_sync u_bus_sync (
        .sys_clk     (sys_clk),
        .resetn      (resetn),
        .i_scl       (scl_in),
        .i_sda       (sda_in),
        .o_sda       (w_sda),
        .o_scl_rise  (w_scl_rise),
        .o_scl_fall  (w_scl_fall),
        .o_start_det (w_start_det),
        .o_stop_det  (w_stop_det)
    );

    // Byte as it stands once the current SCL rise is shifted in
    assign w_rx_byte = {r_shift, w_sda};
    assign w_rd_byte = r_mem[r_ptr];

    // Protocol FSM: bit counting, ACK generation, read shifting and pointer handling
    always_ff @(posedge sys_clk or negedge resetn) begin
        if (!resetn) begin
            r_state     <= ST_IDLE;
            r_ack_next  <= ST_IDLE;
            r_bit_cnt   <= 4'd0;
            r_shift     <= 7'd0;
            r_ptr       <= '0;
            r_sda_oe    <= 1'b0;
            r_busy      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= 8'd0;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_stop_det) begin
                r_state   <= ST_IDLE;
                r_sda_oe  <= 1'b0;
                r_busy    <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else if (w_start_det) begin
                // Also covers repeated START; the pointer is deliberately kept
                r_state   <= ST_ADDR;
                r_sda_oe  <= 1'b0;
                r_bit_cnt <= 4'd0;
            end else begin
                case (r_state)
                    ST_ADDR, ST_PTR, ST_WR_DATA: begin
                        if (w_scl_rise) begin
                            r_shift   <= w_rx_byte[6:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt  <= 4'd0;
                                r_state    <= ST_ACK;
                                r_ack_next <= ST_WR_DATA;
                                if (r_state == ST_ADDR) begin
                                    if (addr_match(w_rx_byte, SLAVE_ADDR)) begin
                                        r_busy     <= 1'b1;
                                        r_ack_next <= w_rx_byte[0] ? ST_RD_DATA : ST_PTR;
                                    end else begin
                                        r_state <= ST_IDLE;
                                        r_busy  <= 1'b0;
                                    end
                                end else if (r_state == ST_PTR) begin
                                    r_ptr <= w_rx_byte[REG_ADDR_W-1:0];
                                end else begin
                                    r_wr_strobe <= 1'b1;
                                    r_wr_addr   <= r_ptr;
                                    r_wr_data   <= w_rx_byte;
                                    r_ptr       <= r_ptr + REG_ADDR_W'(1);
                                end
                            end
                        end
                    end
                    ST_ACK: begin
                        // bit_cnt 0: before the 9th rise; 1: after it
                        if (w_scl_rise) begin
                            r_bit_cnt <= 4'd1;
                        end
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd0) begin
                                r_sda_oe <= ~ACK_LEVEL;
                            end else begin
                                r_bit_cnt <= 4'd0;
                                r_state   <= r_ack_next;
                                if (r_ack_next == ST_RD_DATA) begin
                                    r_shift  <= w_rd_byte[6:0];
                                    r_sda_oe <= ~w_rd_byte[7];
                                end else begin
                                    r_sda_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    ST_RD_DATA: begin
                        if (w_scl_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                        if (w_scl_fall) begin
                            if (r_bit_cnt == 4'd8) begin
                                r_sda_oe  <= 1'b0;
                                r_ptr     <= r_ptr + REG_ADDR_W'(1);
                                r_bit_cnt <= 4'd0;
                                r_state   <= ST_MACK;
                            end else begin
                                r_sda_oe <= ~r_shift[6];
                                r_shift  <= {r_shift[5:0], 1'b0};
                            end
                        end
                    end
                    ST_MACK: begin
                        if (w_scl_rise) begin
                            if (w_sda == NACK_LEVEL) begin
                                r_state <= ST_WAIT_STOP;
                            end else begin
                                r_bit_cnt <= 4'd1;
                            end
                        end
                        if (w_scl_fall && r_bit_cnt == 4'd1) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_RD_DATA;
                            r_shift   <= w_rd_byte[6:0];
                            r_sda_oe  <= ~w_rd_byte[7];
                        end
                    end
                    ST_IDLE, ST_WAIT_STOP: begin
                        r_sda_oe <= 1'b0;
                    end
                    default: begin
                        r_state  <= ST_IDLE;
                        r_sda_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Dual-write register file; an I2C write to the same address overrides the fabric write
    always_ff @(posedge sys_clk) begin
        if (r_wr_strobe) begin
            r_mem[r_wr_addr] <= r_wr_data;
        end
        if (fab_wr_en && !(r_wr_strobe && (fab_wr_addr == r_wr_addr))) begin
            r_mem[fab_wr_addr] <= fab_wr_data;
        end
    end

    assign sda_oe        = r_sda_oe;
    assign busy          = r_busy;
    assign i2c_wr_strobe = r_wr_strobe;
    assign i2c_wr_addr   = r_wr_addr;
    assign i2c_wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb/tb_i2c_target_regfile.sv - self-checking bench for i2c_target_regfile
module tb_i2c_target_regfile;

    localparam int         Q  = 10;
    localparam logic [6:0] SA = 7'h28;

    logic       sys_clk = 1'b0;
    logic       resetn  = 1'b0;
    logic       scl_m   = 1'b1;
    logic       sda_m   = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       fab_wr_en   = 1'b0;
    logic [5:0] fab_wr_addr = 6'd0;
    logic [7:0] fab_wr_data = 8'd0;
    logic       i2c_wr_strobe;
    logic [5:0] i2c_wr_addr;
    logic [7:0] i2c_wr_data;
    logic       busy;

    assign sda_line = sda_m & ~sda_oe;

    always #5 sys_clk = ~sys_clk;

    i2c_target_regfile #(.SLAVE_ADDR(7'h28), .REG_ADDR_W(6)) dut (
        .sys_clk       (sys_clk),
        .resetn        (resetn),
        .scl_in        (scl_m),
        .sda_in        (sda_line),
        .sda_oe        (sda_oe),
        .fab_wr_en     (fab_wr_en),
        .fab_wr_addr   (fab_wr_addr),
        .fab_wr_data   (fab_wr_data),
        .i2c_wr_strobe (i2c_wr_strobe),
        .i2c_wr_addr   (i2c_wr_addr),
        .i2c_wr_data   (i2c_wr_data),
        .busy          (busy)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  m_mem [64];
    logic [5:0]  m_ptr;
    logic [13:0] exp_q [$];
    logic [13:0] obs_q [$];
    int          obs_rd = 0;
    int          oe_cnt = 0;

    always @(negedge sys_clk) begin
        if (i2c_wr_strobe) obs_q.push_back({i2c_wr_addr, i2c_wr_data});
        if (sda_oe) oe_cnt++;
    end

    initial begin
        #(4_000_000);
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wq;
        repeat (Q) @(negedge sys_clk);
    endtask

    task automatic bus_start;
        sda_m = 1'b1; wq; scl_m = 1'b1; wq; sda_m = 1'b0; wq; scl_m = 1'b0; wq;
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; wq; scl_m = 1'b1; wq; sda_m = 1'b1; wq;
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        sda_m = b; wq; scl_m = 1'b1; wq; r = sda_line; wq; scl_m = 1'b0; wq;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
        bit_xfer(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            bit_xfer(1'b1, r);
            d[i] = r;
        end
        bit_xfer(mack ? 1'b0 : 1'b1, r);
    endtask

    task automatic fab_write(input logic [5:0] a, input logic [7:0] d);
        fab_wr_en = 1'b1; fab_wr_addr = a; fab_wr_data = d;
        @(negedge sys_clk);
        fab_wr_en = 1'b0;
        m_mem[a] = d;
    endtask

    task automatic i2c_write(input string tag, input logic [7:0] ptr, input int n, input logic [31:0] bytes);
        logic       ack;
        logic [7:0] d;
        bus_start;
        write_byte({SA, 1'b0}, ack);
        check({tag, " addr ack"}, 32'(ack), 32'd1);
        check({tag, " busy"}, 32'(busy), 32'd1);
        write_byte(ptr, ack);
        check({tag, " ptr ack"}, 32'(ack), 32'd1);
        m_ptr = ptr[5:0];
        for (int i = 0; i < n; i++) begin
            d = bytes[31-8*i -: 8];
            write_byte(d, ack);
            check({tag, " data ack"}, 32'(ack), 32'd1);
            exp_q.push_back({m_ptr, d});
            m_mem[m_ptr] = d;
            m_ptr = m_ptr + 6'd1;
        end
        bus_stop;
        check({tag, " busy after stop"}, 32'(busy), 32'd0);
    endtask

    task automatic i2c_read(input string tag, input logic set_ptr, input logic [7:0] ptr, input int n,
                            output logic [31:0] got);
        logic       ack;
        logic [7:0] d;
        got = 32'd0;
        bus_start;
        if (set_ptr) begin
            write_byte({SA, 1'b0}, ack);
            check({tag, " wr addr ack"}, 32'(ack), 32'd1);
            write_byte(ptr, ack);
            check({tag, " ptr ack"}, 32'(ack), 32'd1);
            m_ptr = ptr[5:0];
            bus_start;
        end
        write_byte({SA, 1'b1}, ack);
        check({tag, " rd addr ack"}, 32'(ack), 32'd1);
        for (int i = 0; i < n; i++) begin
            read_byte(i < n - 1, d);
            check({tag, " rd data"}, 32'(d), 32'(m_mem[m_ptr]));
            got[31-8*i -: 8] = d;
            m_ptr = m_ptr + 6'd1;
        end
        repeat (4) @(negedge sys_clk);
        check({tag, " sda_oe after nack"}, 32'(sda_oe), 32'd0);
        bus_stop;
        check({tag, " busy after stop"}, 32'(busy), 32'd0);
    endtask

    task automatic check_strobes(input string tag);
        repeat (4) @(negedge sys_clk);
        check({tag, " strobe count"}, 32'(obs_q.size() - obs_rd), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && obs_rd + i < obs_q.size(); i++)
            check({tag, " strobe addr/data"}, 32'(obs_q[obs_rd + i]), 32'(exp_q[i]));
        obs_rd = obs_q.size();
        exp_q.delete();
    endtask

    // Waits for the I2C write to i2c_a and launches a fabric write in that same cycle
    task automatic collide(input logic [5:0] i2c_a, input logic [5:0] fab_a, input logic [7:0] fab_d);
        int found = 0;
        for (int c = 0; c < 4000 && found == 0; c++) begin
            @(negedge sys_clk);
            if (i2c_wr_strobe && i2c_wr_addr == i2c_a) found = 1;
        end
        check("collide wait", 32'(found), 32'd1);
        if (found == 1) begin
            fab_wr_en = 1'b1; fab_wr_addr = fab_a; fab_wr_data = fab_d;
            @(negedge sys_clk);
            fab_wr_en = 1'b0;
            m_mem[fab_a] = fab_d;
        end
    endtask

    typedef struct {
        logic [6:0] addr;
        logic [7:0] ptr;
        logic [7:0] data;
        logic       exp_ack;
        logic [5:0] exp_waddr;
    } vec_t;

    vec_t vecs [5];

    initial begin
        logic        ack;
        logic [7:0]  d;
        logic [31:0] got;
        int          oe0;
        int          kind;
        int          n;

        vecs[0] = '{7'h28, 8'h3D, 8'h0C, 1'b1, 6'h3D};
        vecs[1] = '{7'h29, 8'h10, 8'h5A, 1'b0, 6'h00};
        vecs[2] = '{7'h28, 8'hC5, 8'h33, 1'b1, 6'h05};
        vecs[3] = '{7'h14, 8'h00, 8'hFF, 1'b0, 6'h00};
        vecs[4] = '{7'h28, 8'h00, 8'h00, 1'b1, 6'h00};

        repeat (5) @(negedge sys_clk);
        check("reset sda_oe", 32'(sda_oe), 32'd0);
        check("reset strobe", 32'(i2c_wr_strobe), 32'd0);
        check("reset wr_addr", 32'(i2c_wr_addr), 32'd0);
        check("reset wr_data", 32'(i2c_wr_data), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        m_ptr = 6'd0;
        repeat (5) @(negedge sys_clk);

        for (int a = 0; a < 64; a++) fab_write(6'(a), 8'($urandom));

        // Single-byte write vectors, including non-matching addresses
        for (int v = 0; v < 5; v++) begin
            oe0 = oe_cnt;
            bus_start;
            write_byte({vecs[v].addr, 1'b0}, ack);
            check("vec addr ack", 32'(ack), 32'(vecs[v].exp_ack));
            if (vecs[v].exp_ack) begin
                check("vec busy", 32'(busy), 32'd1);
                write_byte(vecs[v].ptr, ack);
                check("vec ptr ack", 32'(ack), 32'd1);
                write_byte(vecs[v].data, ack);
                check("vec data ack", 32'(ack), 32'd1);
                bus_stop;
                repeat (4) @(negedge sys_clk);
                check("vec strobe count", 32'(obs_q.size() - obs_rd), 32'd1);
                if (obs_q.size() > obs_rd)
                    check("vec strobe addr/data", 32'(obs_q[obs_rd]), 32'({vecs[v].exp_waddr, vecs[v].data}));
                m_mem[vecs[v].exp_waddr] = vecs[v].data;
                m_ptr = vecs[v].exp_waddr + 6'd1;
            end else begin
                check("vec mismatch busy", 32'(busy), 32'd0);
                bus_stop;
                repeat (4) @(negedge sys_clk);
                check("vec mismatch strobes", 32'(obs_q.size() - obs_rd), 32'd0);
                check("vec mismatch sda_oe cycles", 32'(oe_cnt - oe0), 32'd0);
            end
            check("vec busy after stop", 32'(busy), 32'd0);
            obs_rd = obs_q.size();
        end

        // Fabric preload, pointer write, repeated START, two-byte read
        fab_write(6'h08, 8'h11);
        fab_write(6'h09, 8'h22);
        i2c_read("t2", 1'b1, 8'h08, 2, got);
        check("t2 byte0", got[31:24], 32'h11);
        check("t2 byte1", got[23:16], 32'h22);

        // Burst write wrapping from the top of the file
        i2c_write("t4", 8'h3F, 2, 32'hAABB_0000);
        check_strobes("t4");
        i2c_read("t4 rb", 1'b1, 8'h3F, 2, got);
        check("t4 reg3F", got[31:24], 32'hAA);
        check("t4 reg00", got[23:16], 32'hBB);

        // STOP inside a data byte, then reset while a 0 bit is being driven
        bus_start;
        write_byte({SA, 1'b0}, ack);
        write_byte(8'h20, ack);
        for (int i = 0; i < 4; i++) bit_xfer(1'b1, ack);
        bus_stop;
        check_strobes("t5 partial");
        fab_write(6'h21, 8'h3C);
        bus_start;
        write_byte({SA, 1'b0}, ack);
        write_byte(8'h21, ack);
        bus_start;
        write_byte({SA, 1'b1}, ack);
        check("t5 driving 0 bit", 32'(sda_oe), 32'd1);
        resetn = 1'b0;
        #1;
        check("t5 async sda_oe", 32'(sda_oe), 32'd0);
        check("t5 async busy", 32'(busy), 32'd0);
        @(negedge sys_clk);
        repeat (3) @(negedge sys_clk);
        resetn = 1'b1;
        m_ptr = 6'd0;
        oe0 = oe_cnt;
        for (int i = 0; i < 3; i++) bit_xfer(1'b1, ack);
        bus_stop;
        check("t5 silent after reset", 32'(oe_cnt - oe0), 32'd0);
        check_strobes("t5 no strobe");
        i2c_write("t5 redo", 8'h3D, 1, 32'h0C00_0000);
        check_strobes("t5 redo");

        // Same-cycle fabric/I2C writes: same address then different addresses
        fab_write(6'h12, 8'h00);
        fork
            i2c_write("t6", 8'h10, 2, 32'h6699_0000);
            begin
                collide(6'h10, 6'h10, 8'h55);
                collide(6'h11, 6'h12, 8'h77);
            end
        join
        check_strobes("t6");
        i2c_read("t6 rb", 1'b1, 8'h10, 3, got);
        check("t6 reg10", got[31:24], 32'h66);
        check("t6 reg11", got[23:16], 32'h99);
        check("t6 reg12", got[15:8], 32'h77);

        // Randomised traffic against the model
        for (int it = 0; it < 8; it++) begin
            kind = $urandom_range(0, 2);
            n = $urandom_range(1, 3);
            d = 8'($urandom);
            if (kind == 0) begin
                i2c_write("rnd wr", d, n, $urandom);
                check_strobes("rnd wr");
            end else begin
                fab_write(6'($urandom), 8'($urandom));
                i2c_read("rnd rd", kind == 1, d, n, got);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
